// File: rtl/univ_deser_rx.sv
// -----------------------------------------------------------------------------
// univ_deser_rx
//
// Serial-to-parallel receiver: the receiving end of a universal shift
// register used as a serializer. One bit per SVLD/SRDY beat is assembled into a
// C_NUM_BITS-wide word, MSB-first (DIR=0) or LSB-first (DIR=1). Each finished
// word is presented on a registered output with a QVLD/QRDY handshake. A
// finished word that cannot be handed over yet is held in the shift register
// (state FULL), which gives double buffering.
//
// Ports
//   CK     in   clock, rising edge
//   R      in   asynchronous active-high reset
//   SDI    in   serial data bit
//   SVLD   in   serial bit valid
//   SRDY   out  receiver can accept a serial bit
//   DIR    in   0 = MSB-first, 1 = LSB-first (latched at the first beat of a frame)
//   ABORT  in   synchronous, discards the partial frame (and a buffered word)
//   Q      out  received word
//   QVLD   out  Q holds an unread word
//   QRDY   in   consumer accepts Q
//   PERR   out  parity error flag for the word in Q
//
// Build option
//   UNIV_DESER_RX_PARITY_EN : each frame carries one extra even-parity bit
//                             after the data bits; PERR reports a mismatch.
//                             When undefined, PERR is constant 0.
// -----------------------------------------------------------------------------
module univ_deser_rx #(
  parameter int C_NUM_BITS = 24
) (
  input  logic                  CK,
  input  logic                  R,
  input  logic                  SDI,
  input  logic                  SVLD,
  output logic                  SRDY,
  input  logic                  DIR,
  input  logic                  ABORT,
  output logic [C_NUM_BITS-1:0] Q,
  output logic                  QVLD,
  input  logic                  QRDY,
  output logic                  PERR
);

  localparam int CNT_W = $clog2(C_NUM_BITS + 1);

`ifdef UNIV_DESER_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Count value of the final beat of a frame (the parity beat when enabled).
  localparam logic [CNT_W-1:0] CNT_LAST = PARITY_EN ? CNT_W'(C_NUM_BITS)
                                                    : CNT_W'(C_NUM_BITS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  function automatic logic [C_NUM_BITS-1:0] shift_in(
    input logic [C_NUM_BITS-1:0] cur,
    input logic                  b,
    input logic                  d
  );
    return d ? {b, cur[C_NUM_BITS-1:1]} : {cur[C_NUM_BITS-2:0], b};
  endfunction

  state_t                  state, state_n;
  logic [C_NUM_BITS-1:0]   sr, sr_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    dir_l, dir_l_n;
  logic [C_NUM_BITS-1:0]   q_n;
  logic                    qvld_n;
  logic                    perr_r, perr_n;
  // Running XOR of the bits of the current frame. While FULL it holds the
  // pending parity-error result of the buffered word.
  logic                    par, par_n;

  logic                    accept;
  logic                    pop;
  logic                    dir_eff;
  logic                    is_last;
  logic                    data_beat;
  logic [C_NUM_BITS-1:0]   word_done;
  logic                    perr_calc;

  assign SRDY      = (state == COLLECT);
  assign accept    = SVLD && SRDY;
  assign pop       = QVLD && QRDY;
  // The first beat of a frame already uses the freshly sampled direction.
  assign dir_eff   = (cnt == '0) ? DIR : dir_l;
  assign is_last   = (cnt == CNT_LAST);
  // The parity beat is never shifted into the word.
  assign data_beat = !(PARITY_EN && is_last);
  assign word_done = PARITY_EN ? sr : shift_in(sr, SDI, dir_eff);
  assign perr_calc = par ^ SDI;
  assign PERR      = PARITY_EN ? perr_r : 1'b0;

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state <= COLLECT;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    dir_l_n = dir_l;
    q_n     = Q;
    qvld_n  = QVLD;
    perr_n  = perr_r;
    par_n   = par;

    // A pop with no new word loaded empties the output; Q keeps its value.
    if (pop) begin
      qvld_n = 1'b0;
    end

    if (ABORT) begin
      // Beats in the same cycle are dropped; the output side is untouched.
      sr_n    = '0;
      cnt_n   = '0;
      par_n   = 1'b0;
      state_n = COLLECT;
    end else begin
      unique case (state)
        COLLECT: begin
          if (accept) begin
            if (cnt == '0) begin
              dir_l_n = DIR;
            end
            if (data_beat) begin
              sr_n  = shift_in(sr, SDI, dir_eff);
              par_n = par ^ SDI;
              cnt_n = cnt + CNT_W'(1);
            end
            if (is_last) begin
              if (!QVLD || pop) begin
                q_n    = word_done;
                qvld_n = 1'b1;
                perr_n = PARITY_EN ? perr_calc : 1'b0;
                cnt_n  = '0;
                par_n  = 1'b0;
              end else begin
                // Output still occupied: park the word in SR until popped.
                state_n = FULL;
                par_n   = perr_calc;
                cnt_n   = cnt;
              end
            end
          end
        end
        FULL: begin
          if (pop) begin
            q_n     = sr;
            qvld_n  = 1'b1;
            perr_n  = PARITY_EN ? par : 1'b0;
            cnt_n   = '0;
            par_n   = 1'b0;
            state_n = COLLECT;
          end
        end
        default: state_n = COLLECT;
      endcase
    end
  end

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      sr     <= '0;
      cnt    <= '0;
      dir_l  <= 1'b0;
      Q      <= '0;
      QVLD   <= 1'b0;
      perr_r <= 1'b0;
      par    <= 1'b0;
    end else begin
      sr     <= sr_n;
      cnt    <= cnt_n;
      dir_l  <= dir_l_n;
      Q      <= q_n;
      QVLD   <= qvld_n;
      perr_r <= perr_n;
      par    <= par_n;
    end
  end

endmodule

// File: tb/tb_univ_deser_rx.sv
// -----------------------------------------------------------------------------
// tb_univ_deser_rx
//
// Directed bench for univ_deser_rx (C_NUM_BITS = 24). Inputs change 1 ns after
// the rising edge, outputs are sampled at that same point, i.e. away from the
// active edge. Expected values are hand-written constants.
// -----------------------------------------------------------------------------
module tb_univ_deser_rx;

  localparam int N = 24;
`ifdef UNIV_DESER_RX_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  logic         CK;
  logic         R;
  logic         SDI;
  logic         SVLD;
  logic         SRDY;
  logic         DIR;
  logic         ABORT;
  logic [N-1:0] Q;
  logic         QVLD;
  logic         QRDY;
  logic         PERR;

  int n_cmp;
  int n_bad;
  int srdy_low;

  univ_deser_rx #(.C_NUM_BITS(N)) dut (
    .CK    (CK),
    .R     (R),
    .SDI   (SDI),
    .SVLD  (SVLD),
    .SRDY  (SRDY),
    .DIR   (DIR),
    .ABORT (ABORT),
    .Q     (Q),
    .QVLD  (QVLD),
    .QRDY  (QRDY),
    .PERR  (PERR)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Sends beats [from, to) of a frame; beat k < N carries a data bit in the
  // order selected by d, beat N carries the parity bit p. DIR is not touched.
  task automatic send_seq(input logic [31:0] w, input logic d, input logic p,
                          input int from, input int to);
    for (int k = from; k < to; k++) begin
      if (k < N) SDI = d ? w[k] : w[N-1-k];
      else       SDI = p;
      SVLD = 1'b1;
      if (!SRDY) srdy_low++;
      tick();
    end
    SVLD = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic d);
    logic [N-1:0] wn;
    wn  = w[N-1:0];
    DIR = d;
    send_seq(w, d, ^wn, 0, FRAME);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    srdy_low = 0;
    R     = 1'b1;
    SDI   = 1'b0;
    SVLD  = 1'b0;
    DIR   = 1'b0;
    ABORT = 1'b0;
    QRDY  = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    R = 1'b0;
    check("rst_q", Q, 32'h0);
    check("rst_qvld", QVLD, 32'h0);
    check("rst_srdy", SRDY, 32'h1);
    check("rst_perr", PERR, 32'h0);

    // 1: MSB-first, consumer always ready
    QRDY = 1'b1;
    send_word(32'hA5C3F0, 1'b0);
    check("t1_qvld", QVLD, 32'h1);
    check("t1_q", Q, 32'hA5C3F0);
    check("t1_srdy_never_low", srdy_low, 32'h0);
`ifndef UNIV_DESER_RX_PARITY_EN
    check("t1_perr_tied", PERR, 32'h0);
`endif
    tick();
    check("t1_pop_qvld", QVLD, 32'h0);
    check("t1_pop_q_kept", Q, 32'hA5C3F0);

    // 2: LSB-first, DIR toggled mid-frame must be ignored
    DIR = 1'b1;
    send_seq(32'h000001, 1'b1, 1'b1, 0, 5);
    DIR = 1'b0;
    send_seq(32'h000001, 1'b1, 1'b1, 5, FRAME);
    check("t2_q", Q, 32'h000001);
    check("t2_qvld", QVLD, 32'h1);
    tick();

    // 3: consumer stalled, second word buffered
    QRDY = 1'b0;
    send_word(32'h123456, 1'b0);
    check("t3_first_q", Q, 32'h123456);
    send_word(32'h654321, 1'b0);
    check("t3_full_srdy", SRDY, 32'h0);
    check("t3_full_q", Q, 32'h123456);
    check("t3_full_qvld", QVLD, 32'h1);
    QRDY = 1'b1;
    tick();
    QRDY = 1'b0;
    check("t3_pop_q", Q, 32'h654321);
    check("t3_pop_qvld", QVLD, 32'h1);
    check("t3_pop_srdy", SRDY, 32'h1);
    QRDY = 1'b1;
    tick();
    QRDY = 1'b0;
    check("t3_drain_qvld", QVLD, 32'h0);

    // 4: ABORT drops a partial frame while Q holds an unread word
    send_word(32'h111111, 1'b0);
    check("t4_hold_q", Q, 32'h111111);
    DIR = 1'b0;
    send_seq(32'hFFFFFF, 1'b0, 1'b0, 0, 10);
    SDI   = 1'b1;
    SVLD  = 1'b1;
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    SVLD  = 1'b0;
    check("t4_abort_q", Q, 32'h111111);
    check("t4_abort_qvld", QVLD, 32'h1);
    check("t4_abort_srdy", SRDY, 32'h1);
    QRDY = 1'b1;
    tick();
    QRDY = 1'b0;
    check("t4_pop_qvld", QVLD, 32'h0);
    send_seq(32'hFFFFFF, 1'b0, 1'b0, 0, FRAME - 1);
    check("t4_no_early_word", QVLD, 32'h0);
    send_seq(32'hFFFFFF, 1'b0, 1'b0, FRAME - 1, FRAME);
    check("t4_q", Q, 32'hFFFFFF);
    check("t4_qvld", QVLD, 32'h1);

    // 5: asynchronous reset mid-frame
    send_seq(32'h5A5A5A, 1'b0, 1'b0, 0, 12);
    #2;
    R = 1'b1;
    #1;
    check("t5_rst_q", Q, 32'h0);
    check("t5_rst_qvld", QVLD, 32'h0);
    #1;
    R = 1'b0;
    check("t5_rst_srdy", SRDY, 32'h1);
    tick();
    send_word(32'h5A5A5A, 1'b0);
    check("t5_q", Q, 32'h5A5A5A);
    check("t5_qvld", QVLD, 32'h1);

`ifdef UNIV_DESER_RX_PARITY_EN
    // 6: parity check
    QRDY = 1'b1;
    DIR  = 1'b0;
    send_seq(32'h000003, 1'b0, 1'b0, 0, FRAME);
    check("t6_good_q", Q, 32'h000003);
    check("t6_good_perr", PERR, 32'h0);
    send_seq(32'h000001, 1'b0, 1'b0, 0, FRAME);
    check("t6_bad_q", Q, 32'h000001);
    check("t6_bad_perr", PERR, 32'h1);
`else
    check("t5_perr_tied", PERR, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
